// File: rtl/timer_pkg.sv
// Shared constants for the 60 Hz timer bank: clock rates, prescaler divisor and CHIP-8 channel indices.
package timer_pkg;

  localparam int unsigned CLK50_HZ      = 50_000_000;
  localparam int unsigned CHIP8_TICK_HZ = 60;

  localparam int unsigned CH_DELAY = 0;
  localparam int unsigned CH_SOUND = 1;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Down-counting prescaler emitting a one-cycle tick every DIV clocks.
// Optional TIMER_BANK_PAUSE_EN adds a pause input that freezes the count and masks the tick.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned DIV = calc_div(CLK50_HZ, CHIP8_TICK_HZ)
) (
  input  logic clk50,
  input  logic reset,
`ifdef TIMER_BANK_PAUSE_EN
  input  logic pause,
`endif
  output logic tick
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("timer_prescaler: DIV must be at least 2");
  end

  logic [CW-1:0] count_q, count_d;
  logic          run;

`ifdef TIMER_BANK_PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (run) count_d = (count_q == '0) ? RELOAD : count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk50) begin
    if (reset) count_q <= RELOAD;
    else       count_q <= count_d;
  end

  assign tick = run && (count_q == '0);

endmodule

// File: rtl/timer_bank_60hz.sv
// Bank of NUM_CH down-counting timers sharing one TICK_HZ prescaler, with active/expired flags and a registered read port.
// Optional TIMER_BANK_PAUSE_EN adds a pause input that freezes ticking while reads and writes continue.
module timer_bank_60hz
  import timer_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 2,
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned CLK_HZ  = CLK50_HZ,
  parameter  int unsigned TICK_HZ = CHIP8_TICK_HZ,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk50,
  input  logic              reset,
`ifdef TIMER_BANK_PAUSE_EN
  input  logic              pause,
`endif
  input  logic              we,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [WIDTH-1:0]  rd_data,
  output logic              tick,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] expired,
  output logic              any_active
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

  timer_prescaler #(.DIV(DIV)) u_prescaler (
    .clk50 (clk50),
    .reset (reset),
`ifdef TIMER_BANK_PAUSE_EN
    .pause (pause),
`endif
    .tick  (tick)
  );

  logic [WIDTH-1:0] values [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] value_q, value_d;
    logic             expired_q, expired_d;
    logic             wr_hit;

    assign wr_hit = we && (wr_ch == CH_W'(i));

    // A write takes precedence over a same-cycle tick and never raises expired.
    always_comb begin
      value_d   = value_q;
      expired_d = 1'b0;
      if (wr_hit) begin
        value_d = wdata;
      end else if (tick && (value_q != '0)) begin
        value_d   = value_q - 1'b1;
        expired_d = (value_q == WIDTH'(1));
      end
    end

    always_ff @(posedge clk50) begin
      if (reset) begin
        value_q   <= '0;
        expired_q <= 1'b0;
      end else begin
        value_q   <= value_d;
        expired_q <= expired_d;
      end
    end

    assign values[i]  = value_q;
    assign active[i]  = (value_q != '0);
    assign expired[i] = expired_q;
  end

  assign any_active = |active;

  // Out-of-range channel selects fall through to zero.
  logic [WIDTH-1:0] rd_sel;
  logic [WIDTH-1:0] rd_data_q;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_sel = values[i];
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_sel;
  end

  assign rd_data = rd_data_q;

endmodule
